// File: rtl/adpll_boot_seq.sv
// CPU-less bus initiator that programs the ADPLL after power-up and polls for lock.
// Optional post-lock saturation read is enabled by defining ADPLL_BOOT_SAT_CHECK_EN.
`timescale 1ns/1ps

`ifndef ADPLL_ADDR_W
`define ADPLL_ADDR_W 8
`endif
`ifndef FCWW
`define FCWW 26
`endif
`ifndef ADPLL_SOFT_RST
`define ADPLL_SOFT_RST 'h00
`endif
`ifndef FCW
`define FCW 'h04
`endif
`ifndef ADPLL_MODE
`define ADPLL_MODE 'h08
`endif
`ifndef ADPLL_EN
`define ADPLL_EN 'h0C
`endif
`ifndef ADPLL_LOCK
`define ADPLL_LOCK 'h10
`endif
`ifndef ADPLL_SAT
`define ADPLL_SAT 'h14
`endif

module adpll_boot_seq #(
  parameter int ADDR_W   = `ADPLL_ADDR_W,
  parameter int POLL_MAX = 1024,
  parameter int POLL_GAP = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [`FCWW-1:0]  fcw,
  input  logic [1:0]        mode,
  output logic              valid,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       wdata,
  output logic              wstrb,
  input  logic [31:0]       rdata,
  input  logic              ready,
  output logic              busy,
  output logic              done,
  output logic              locked,
  output logic              timeout,
`ifdef ADPLL_BOOT_SAT_CHECK_EN
  output logic              sat_err,
`endif
  output logic [15:0]       poll_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_W_RST1, S_W_RST0, S_W_FCW, S_W_MODE, S_W_EN,
    S_R_LOCK, S_WAIT, S_R_SAT, S_W_DIS, S_FIN
  } state_t;

  localparam logic [15:0] PMAX     = (POLL_MAX >= 65535) ? 16'hFFFF : 16'(POLL_MAX);
  localparam logic [15:0] GAP_LAST = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;

  state_t           r_state, w_next;
  logic             r_gap, r_rd_bit, r_locked, r_timeout, r_sat_err;
  logic [15:0]      r_poll_cnt, r_wait_cnt;
  logic [`FCWW-1:0] r_fcw;
  logic [1:0]       r_mode;
  logic             w_access, w_req, w_ack, w_accept;
  logic             w_unused;

  // Each access state spends its request phase until ready, then one gap cycle.
  assign w_access = r_state inside {S_W_RST1, S_W_RST0, S_W_FCW, S_W_MODE, S_W_EN,
                                    S_R_LOCK, S_R_SAT, S_W_DIS};
  assign w_req    = w_access & ~r_gap;
  assign w_ack    = w_req & ready;
  assign w_accept = (r_state == S_IDLE) & start;
  assign w_unused = ^rdata[31:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_W_RST1;
      S_W_RST1: if (r_gap) w_next = S_W_RST0;
      S_W_RST0: if (r_gap) w_next = S_W_FCW;
      S_W_FCW:  if (r_gap) w_next = S_W_MODE;
      S_W_MODE: if (r_gap) w_next = S_W_EN;
      S_W_EN:   if (r_gap) w_next = S_R_LOCK;
      S_R_LOCK: if (r_gap) begin
        if (r_rd_bit)
`ifdef ADPLL_BOOT_SAT_CHECK_EN
          w_next = S_R_SAT;
`else
          w_next = S_FIN;
`endif
        else if (r_poll_cnt >= PMAX) w_next = S_W_DIS;
        else if (POLL_GAP == 0)      w_next = S_R_LOCK;
        else                         w_next = S_WAIT;
      end
      S_WAIT:   if (r_wait_cnt == GAP_LAST) w_next = S_R_LOCK;
`ifdef ADPLL_BOOT_SAT_CHECK_EN
      S_R_SAT:  if (r_gap) w_next = r_rd_bit ? S_W_DIS : S_FIN;
`endif
      S_W_DIS:  if (r_gap) w_next = S_FIN;
      S_FIN:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    valid   = w_req;
    address = '0;
    wdata   = '0;
    wstrb   = 1'b0;
    busy    = (r_state != S_IDLE);
    done    = (r_state == S_FIN);
    if (w_req) begin
      case (r_state)
        S_W_RST1: begin address = ADDR_W'(`ADPLL_SOFT_RST); wdata = 32'd1; wstrb = 1'b1; end
        S_W_RST0: begin address = ADDR_W'(`ADPLL_SOFT_RST); wdata = 32'd0; wstrb = 1'b1; end
        S_W_FCW:  begin address = ADDR_W'(`FCW); wdata = 32'(r_fcw); wstrb = 1'b1; end
        S_W_MODE: begin address = ADDR_W'(`ADPLL_MODE); wdata = {30'd0, r_mode}; wstrb = 1'b1; end
        S_W_EN:   begin address = ADDR_W'(`ADPLL_EN); wdata = 32'd1; wstrb = 1'b1; end
        S_R_LOCK: address = ADDR_W'(`ADPLL_LOCK);
        S_R_SAT:  address = ADDR_W'(`ADPLL_SAT);
        S_W_DIS:  begin address = ADDR_W'(`ADPLL_EN); wdata = 32'd0; wstrb = 1'b1; end
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap      <= 1'b0;
      r_rd_bit   <= 1'b0;
      r_locked   <= 1'b0;
      r_timeout  <= 1'b0;
      r_sat_err  <= 1'b0;
      r_poll_cnt <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_gap      <= w_ack;
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 16'd1 : 16'd0;
      if (w_ack) r_rd_bit <= rdata[0];
      if (w_accept) begin
        r_locked   <= 1'b0;
        r_timeout  <= 1'b0;
        r_sat_err  <= 1'b0;
        r_poll_cnt <= '0;
      end
      if (w_ack && r_state == S_R_LOCK) begin
        if (r_poll_cnt != 16'hFFFF) r_poll_cnt <= r_poll_cnt + 16'd1;
        if (rdata[0]) r_locked <= 1'b1;
      end
      // A saturated loop counts as a failed boot even though lock was reported.
      if (w_ack && r_state == S_R_SAT && rdata[0]) begin
        r_locked  <= 1'b0;
        r_timeout <= 1'b1;
        r_sat_err <= 1'b1;
      end
      if (r_state == S_W_DIS && r_gap) r_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_fcw  <= fcw;
      r_mode <= mode;
    end
  end

  assign locked   = r_locked;
  assign timeout  = r_timeout;
  assign poll_cnt = r_poll_cnt;
`ifdef ADPLL_BOOT_SAT_CHECK_EN
  assign sat_err  = r_sat_err;
`endif

endmodule

// File: tb/tb_adpll_boot_seq.sv
// Randomized bench for adpll_boot_seq: register-block responder plus a transaction-level
// model of the expected boot trace, outcome flags and completion time.
`timescale 1ns/1ps

`ifndef ADPLL_ADDR_W
`define ADPLL_ADDR_W 8
`endif
`ifndef FCWW
`define FCWW 26
`endif
`ifndef ADPLL_SOFT_RST
`define ADPLL_SOFT_RST 'h00
`endif
`ifndef FCW
`define FCW 'h04
`endif
`ifndef ADPLL_MODE
`define ADPLL_MODE 'h08
`endif
`ifndef ADPLL_EN
`define ADPLL_EN 'h0C
`endif
`ifndef ADPLL_LOCK
`define ADPLL_LOCK 'h10
`endif
`ifndef ADPLL_SAT
`define ADPLL_SAT 'h14
`endif

module tb_adpll_boot_seq;
  localparam int AW   = `ADPLL_ADDR_W;
  localparam int FW   = `FCWW;
  localparam int PMAX = 8;
  localparam int PGAP = 16;
  localparam logic [AW-1:0] A_RST  = AW'(`ADPLL_SOFT_RST);
  localparam logic [AW-1:0] A_FCW  = AW'(`FCW);
  localparam logic [AW-1:0] A_MODE = AW'(`ADPLL_MODE);
  localparam logic [AW-1:0] A_EN   = AW'(`ADPLL_EN);
  localparam logic [AW-1:0] A_LOCK = AW'(`ADPLL_LOCK);
  localparam logic [AW-1:0] A_SAT  = AW'(`ADPLL_SAT);

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b0;
  logic [FW-1:0] fcw = '0;
  logic [1:0]    mode = 2'd0;
  logic [31:0]   rdata = 32'd0;
  logic          valid, wstrb, busy, done, locked, timeout;
  logic [AW-1:0] address;
  logic [31:0]   wdata;
  logic [15:0]   poll_cnt;
`ifdef ADPLL_BOOT_SAT_CHECK_EN
  logic          sat_err;
`endif

  adpll_boot_seq #(.ADDR_W(AW), .POLL_MAX(PMAX), .POLL_GAP(PGAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fcw(fcw), .mode(mode),
    .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready), .busy(busy), .done(done),
    .locked(locked), .timeout(timeout),
`ifdef ADPLL_BOOT_SAT_CHECK_EN
    .sat_err(sat_err),
`endif
    .poll_cnt(poll_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {logic [AW-1:0] a; logic [31:0] d; logic w; int c;} acc_t;

  int   n_checks = 0, n_pass = 0;
  int   cyc = 0;
  acc_t trace[$];
  int   rsp_dly = 0, rsp_lock_at = 0, rsp_reads = 0;
  bit   rsp_sat = 1'b0, inject_stray = 1'b0;
  int   hold_viol = 0, gap_viol = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Register-block responder: ready is a registered echo of valid, optionally delayed.
  initial begin
    logic          nr, bitv;
    int            cnt;
    bit            held_v, gap_chk;
    logic [AW-1:0] ha;
    logic [31:0]   hd, rnd;
    logic          hw;
    cnt = 0; held_v = 0; gap_chk = 0; ha = '0; hd = '0; hw = 1'b0;
    forever begin
      @(negedge clk);
      nr = 1'b0; bitv = 1'b0;
      if (!rst_n) begin
        cnt = 0; held_v = 0; gap_chk = 0;
      end else begin
        if (gap_chk && valid) gap_viol++;
        gap_chk = 0;
        if (valid) begin
          if (held_v && (address !== ha || wdata !== hd || wstrb !== hw)) hold_viol++;
          held_v = 1; ha = address; hd = wdata; hw = wstrb;
        end
        if (valid && ready) begin
          trace.push_back('{a: address, d: wdata, w: wstrb, c: cyc});
          held_v = 0; gap_chk = 1; nr = 1'b1;
        end else if (valid) begin
          if (cnt == rsp_dly) begin
            nr = 1'b1; cnt = 0;
            if (!wstrb && address == A_LOCK) begin
              rsp_reads++;
              bitv = (rsp_lock_at != 0) && (rsp_reads >= rsp_lock_at);
            end else if (!wstrb && address == A_SAT) begin
              bitv = rsp_sat;
            end
          end else begin
            cnt++;
          end
        end
      end
      @(posedge clk);
      #1;
      rnd   = $urandom();
      ready = nr | inject_stray;
      rdata = {rnd[31:1], bitv};
    end
  end

  task automatic run_seq(input logic [FW-1:0] f, input logic [1:0] m, input int lock_at,
                         input bit sat, input int dly, input bit poke, input string nm);
    acc_t exp[$];
    int   nlock, exp_done, s, ndone, dc, idle_after, bad_gap, prev_c;
    bit   lk, e_locked, e_timeout, e_sat;
    trace.delete();
    rsp_dly = dly; rsp_lock_at = lock_at; rsp_reads = 0; rsp_sat = sat;
    hold_viol = 0; gap_viol = 0;

    lk        = (lock_at != 0) && (lock_at <= PMAX);
    nlock     = lk ? lock_at : PMAX;
    e_locked  = lk;
    e_timeout = !lk;
    e_sat     = 1'b0;
    exp.push_back('{A_RST, 32'd1, 1'b1, 0});
    exp.push_back('{A_RST, 32'd0, 1'b1, 0});
    exp.push_back('{A_FCW, 32'(f), 1'b1, 0});
    exp.push_back('{A_MODE, {30'd0, m}, 1'b1, 0});
    exp.push_back('{A_EN, 32'd1, 1'b1, 0});
    for (int i = 0; i < nlock; i++) exp.push_back('{A_LOCK, 32'd0, 1'b0, 0});
`ifdef ADPLL_BOOT_SAT_CHECK_EN
    if (lk) begin
      exp.push_back('{A_SAT, 32'd0, 1'b0, 0});
      if (sat) begin e_locked = 1'b0; e_timeout = 1'b1; e_sat = 1'b1; end
    end
`endif
    if (e_timeout) exp.push_back('{A_EN, 32'd0, 1'b1, 0});
    exp_done = 1 + exp.size() * (3 + dly) + (nlock - 1) * PGAP;

    @(negedge clk);
    fcw = f; mode = m; start = 1'b1; s = cyc;
    ndone = 0; dc = -1; idle_after = 0;
    for (int k = 0; k < 1000 && idle_after < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 0) begin fcw = FW'($urandom()); mode = 2'($urandom()); end
      if (done) begin ndone++; if (dc < 0) dc = cyc - s; end
      if (ndone > 0 && !busy) idle_after++;
      else if (poke && busy && $urandom_range(0, 3) == 0) begin
        start = 1'b1; fcw = FW'($urandom()); mode = 2'($urandom());
      end
    end
    start = 1'b0;

    check_val({nm, "_done_cnt"}, 64'(ndone), 64'(1));
    check_val({nm, "_done_cyc"}, 64'(dc), 64'(exp_done));
    check_val({nm, "_locked"}, 64'(locked), 64'(e_locked));
    check_val({nm, "_timeout"}, 64'(timeout), 64'(e_timeout));
    check_val({nm, "_poll_cnt"}, 64'(poll_cnt), 64'(nlock));
    check_val({nm, "_busy"}, 64'(busy), 64'(0));
`ifdef ADPLL_BOOT_SAT_CHECK_EN
    check_val({nm, "_sat_err"}, 64'(sat_err), 64'(e_sat));
`endif
    check_val({nm, "_hold"}, 64'(hold_viol), 64'(0));
    check_val({nm, "_gap"}, 64'(gap_viol), 64'(0));
    check_val({nm, "_trace_len"}, 64'(trace.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < trace.size(); i++) begin
      check_val($sformatf("%s_tr%0d_addr", nm, i), 64'(trace[i].a), 64'(exp[i].a));
      check_val($sformatf("%s_tr%0d_wstrb", nm, i), 64'(trace[i].w), 64'(exp[i].w));
      if (exp[i].w)
        check_val($sformatf("%s_tr%0d_wdata", nm, i), 64'(trace[i].d), 64'(exp[i].d));
    end
    bad_gap = 0; prev_c = -1;
    foreach (trace[i]) begin
      if (trace[i].a == A_LOCK && !trace[i].w) begin
        if (prev_c >= 0 && trace[i].c - prev_c != 3 + dly + PGAP) bad_gap++;
        prev_c = trace[i].c;
      end
    end
    check_val({nm, "_lock_spacing"}, 64'(bad_gap), 64'(0));
  endtask

  task automatic check_reset_outputs(input string nm);
    check_val({nm, "_valid"}, 64'(valid), 64'(0));
    check_val({nm, "_address"}, 64'(address), 64'(0));
    check_val({nm, "_wdata"}, 64'(wdata), 64'(0));
    check_val({nm, "_wstrb"}, 64'(wstrb), 64'(0));
    check_val({nm, "_busy"}, 64'(busy), 64'(0));
    check_val({nm, "_done"}, 64'(done), 64'(0));
    check_val({nm, "_locked"}, 64'(locked), 64'(0));
    check_val({nm, "_timeout"}, 64'(timeout), 64'(0));
    check_val({nm, "_poll_cnt"}, 64'(poll_cnt), 64'(0));
  endtask

  initial begin
    bit found;
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Stray ready while idle must not start anything.
    trace.delete();
    inject_stray = 1'b1;
    @(negedge clk);
    inject_stray = 1'b0;
    check_val("stray_ready_seen", 64'(ready), 64'(1));
    check_val("stray_valid", 64'(valid), 64'(0));
    check_val("stray_busy", 64'(busy), 64'(0));
    repeat (2) @(negedge clk);
    check_val("stray_trace", 64'(trace.size()), 64'(0));

    run_seq(26'h2620000, 2'd0, 1, 1'b0, 0, 1'b0, "nominal");
    run_seq(FW'($urandom()), 2'd1, 6, 1'b0, 0, 1'b0, "delayed");
    run_seq(FW'($urandom()), 2'd2, 0, 1'b0, 0, 1'b0, "timeout");
    run_seq(FW'($urandom()), 2'd3, 2, 1'b0, 3, 1'b1, "handshake");
    run_seq(FW'($urandom()), 2'd1, PMAX, 1'b0, 1, 1'b1, "lock_at_max");
    run_seq(FW'($urandom()), 2'd2, PMAX + 1, 1'b0, 0, 1'b1, "lock_past_max");
`ifdef ADPLL_BOOT_SAT_CHECK_EN
    run_seq(FW'($urandom()), 2'd0, 1, 1'b1, 0, 1'b0, "sat_hit");
    run_seq(FW'($urandom()), 2'd0, 3, 1'b0, 0, 1'b0, "sat_clear");
`endif

    // Reset while a lock read is on the bus.
    rsp_dly = 0; rsp_lock_at = 0; rsp_reads = 0;
    @(negedge clk);
    fcw = FW'($urandom()); mode = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (valid && address == A_LOCK && poll_cnt != 16'd0) begin found = 1'b1; break; end
    end
    check_val("midpoll_reached", 64'(found), 64'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midpoll_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_seq(FW'($urandom()), 2'd2, 3, 1'b0, 0, 1'b1, "after_rst");

    for (int r = 0; r < 10; r++)
      run_seq(FW'($urandom()), 2'($urandom()), $urandom_range(0, PMAX + 2),
              1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'b1, $sformatf("rnd%0d", r));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
